// File: rtl/multiplier_seq.sv
// rtl/multiplier_seq.sv - sequential shift-add unsigned multiplier with valid/ready handshakes
// Optional feature: define MULTIPLIER_SEQ_EARLY_DONE_EN to finish as soon as the
// remaining multiplier bits are all zero (the product value is unchanged).
module multiplier_seq #(
  parameter int MULTIPLICAND_WIDTH = 3,
  parameter int MULTIPLIER_WIDTH   = 2
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [MULTIPLICAND_WIDTH-1:0]                multiplicand,
  input  logic [MULTIPLIER_WIDTH-1:0]                  multiplier,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH-1:0] product
);

  localparam int PW = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH;
  // Counter only has to reach MULTIPLIER_WIDTH-1; keep at least one bit.
  localparam int CW = (MULTIPLIER_WIDTH > 1) ? $clog2(MULTIPLIER_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(MULTIPLIER_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [PW-1:0]           r_mcand;
  logic [MULTIPLIER_WIDTH-1:0] r_mplier;
  logic [PW-1:0]           r_acc;
  logic [CW-1:0]           r_cnt;
  logic [PW-1:0]           r_product;

  logic                    w_accept;
  logic                    w_last;
  logic [PW-1:0]           w_addend;
  logic [PW-1:0]           w_acc_next;

  assign w_accept   = (r_state == IDLE) && in_valid && !reset;
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;

`ifdef MULTIPLIER_SEQ_EARLY_DONE_EN
  // Stop once no set multiplier bits remain after this edge's shift.
  assign w_last = (r_cnt == LAST) || ((r_mplier >> 1) == '0);
`else
  assign w_last = (r_cnt == LAST);
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: accept, iterate over multiplier bits, wait for consumer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_next = BUSY;
      BUSY:    if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, one shift-add step per BUSY edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      if (w_accept) begin
        r_mcand  <= PW'(multiplicand);
        r_mplier <= multiplier;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == BUSY) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          r_product <= w_acc_next;
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE) && !reset;
  assign out_valid = (r_state == DONE);
  assign product   = r_product;

endmodule
